// File: rtl/filter_mc_if.sv
// Frame-level interface of filter_mc: voice samples and filter controls in,
// mixed sample plus status pulses out.
interface filter_mc_if #(
    parameter int DW  = 8,
    parameter int NCH = 3,
    parameter int FW  = 4
) ();
    logic [NCH*DW-1:0] sample_in;
    logic              sample_valid;
    logic              ready;
    logic [NCH-1:0]    filt;
    logic [2:0]        mode;
    logic [FW-1:0]     fc;
    logic [3:0]        res;
    logic [3:0]        vol;
    logic [DW-1:0]     sample_out;
    logic              out_valid;
    logic              overrun;

    modport master (
        output sample_in, sample_valid, filt, mode, fc, res, vol,
        input  ready, sample_out, out_valid, overrun
    );

    modport slave (
        input  sample_in, sample_valid, filt, mode, fc, res, vol,
        output ready, sample_out, out_valid, overrun
    );
endinterface

// File: rtl/filter_mc.sv
// Multi-channel voice mixer with a shared Chamberlin state-variable filter,
// evaluated sequentially (NCH+4 cycles per frame) on one adder and one multiplier.
//
// state  | meaning
// IDLE   | waiting for a frame, ready = 1
// MIX    | add voice ch_idx into xf (filtered) or xb (bypass)
// HP     | hp = xf - lp - damping*bp
// BP     | bp += f*hp
// LP     | lp += f*bp
// OUT    | mode mix + bypass, clamp, volume, update sample_out
module filter_mc #(
    parameter int DW  = 8,
    parameter int NCH = 3,
    parameter int FW  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    filter_mc_if.slave  bus
);
    localparam int IW  = DW + 4;
    localparam int MBW = (FW + 1 > 5) ? FW + 1 : 5;
    localparam int WW  = IW + MBW + 2;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic signed [WW-1:0] IMAX = WW'(2**(IW-1) - 1);
    localparam logic signed [WW-1:0] IMIN = WW'(-(2**(IW-1)));
    localparam logic signed [WW-1:0] DMAX = WW'(2**(DW-1) - 1);
    localparam logic signed [WW-1:0] DMIN = WW'(-(2**(DW-1)));

    typedef enum logic [2:0] {S_IDLE, S_MIX, S_HP, S_BP, S_LP, S_OUT} state_t;

    state_t state, state_nxt;

    logic [NCH*DW-1:0]     sample_r;
    logic [NCH-1:0]        filt_r;
    logic [2:0]            mode_r;
    logic [FW-1:0]         fc_r;
    logic [3:0]            res_r;
    logic [3:0]            vol_r;
    logic [CW-1:0]         ch_idx;
    logic signed [IW-1:0]  xf, xb, hp, bp, lp;
    logic [DW-1:0]         sample_out_r;
    logic                  out_valid_r;
    logic                  overrun_r;

    logic                  ready;
    logic signed [IW-1:0]  mul_a;
    logic [MBW-1:0]        mul_b;
    logic [4:0]            sh;
    logic signed [WW-1:0]  prod, shifted;
    logic signed [WW-1:0]  add_a, add_b;
    logic signed [IW-1:0]  add_res;
    logic [DW-1:0]         smp_k;
    logic signed [DW-1:0]  s_k;
    logic signed [IW-1:0]  sel_lo, sel, t_sum, t_clamp;
    logic [DW-1:0]         o_val;

    function automatic logic signed [WW-1:0] ext_iw(input logic signed [IW-1:0] v);
        return {{(WW-IW){v[IW-1]}}, v};
    endfunction

    function automatic logic signed [IW-1:0] sat_iw(input logic signed [WW-1:0] v);
        if (v > IMAX)      return IMAX[IW-1:0];
        else if (v < IMIN) return IMIN[IW-1:0];
        else               return v[IW-1:0];
    endfunction

    // Offset-binary to two's complement: flipping the MSB subtracts midscale.
    assign smp_k = sample_r[ch_idx*DW +: DW];
    assign s_k   = {~smp_k[DW-1], smp_k[DW-2:0]};

    assign sel_lo = sat_iw(ext_iw(mode_r[0] ? lp : '0) + ext_iw(mode_r[1] ? bp : '0));
    assign sel    = sat_iw(ext_iw(sel_lo) + ext_iw(mode_r[2] ? hp : '0));
    assign t_sum  = sat_iw(ext_iw(sel) + ext_iw(xb));

    always_comb begin
        t_clamp = t_sum;
        if (ext_iw(t_sum) > DMAX)      t_clamp = DMAX[IW-1:0];
        else if (ext_iw(t_sum) < DMIN) t_clamp = DMIN[IW-1:0];
    end

    assign prod    = ext_iw(mul_a) * $signed({{(WW-MBW){1'b0}}, mul_b});
    assign shifted = prod >>> sh;
    assign add_res = sat_iw(add_a + add_b);
    assign o_val   = shifted[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.sample_valid) state_nxt = S_MIX;
            S_MIX:   if (ch_idx == CW'(NCH - 1)) state_nxt = S_HP;
            S_HP:    state_nxt = S_BP;
            S_BP:    state_nxt = S_LP;
            S_LP:    state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Multiplier operand selection; res is turned into a 16-res damping factor.
    always_comb begin
        ready = (state == S_IDLE);
        mul_a = '0;
        mul_b = '0;
        sh    = '0;
        unique case (state)
            S_HP: begin
                mul_a = bp;
                mul_b = MBW'(16) - MBW'(res_r);
                sh    = 5'd3;
            end
            S_BP: begin
                mul_a = hp;
                mul_b = MBW'(fc_r);
                sh    = 5'(FW);
            end
            S_LP: begin
                mul_a = bp;
                mul_b = MBW'(fc_r);
                sh    = 5'(FW);
            end
            S_OUT: begin
                mul_a = t_clamp;
                mul_b = MBW'(vol_r);
                sh    = 5'd4;
            end
            default: ;
        endcase
    end

    always_comb begin
        add_a = '0;
        add_b = '0;
        unique case (state)
            S_MIX: begin
                add_a = ext_iw(filt_r[ch_idx] ? xf : xb);
                add_b = {{(WW-DW){s_k[DW-1]}}, s_k};
            end
            S_HP: begin
                add_a = ext_iw(sat_iw(ext_iw(xf) - ext_iw(lp)));
                add_b = -shifted;
            end
            S_BP: begin
                add_a = ext_iw(bp);
                add_b = shifted;
            end
            S_LP: begin
                add_a = ext_iw(lp);
                add_b = shifted;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_r     <= '0;
            filt_r       <= '0;
            mode_r       <= '0;
            fc_r         <= '0;
            res_r        <= '0;
            vol_r        <= '0;
            ch_idx       <= '0;
            xf           <= '0;
            xb           <= '0;
            hp           <= '0;
            bp           <= '0;
            lp           <= '0;
            sample_out_r <= {1'b1, {(DW-1){1'b0}}};
            out_valid_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            out_valid_r <= (state == S_OUT);
            overrun_r   <= bus.sample_valid && !ready;
            unique case (state)
                S_IDLE: if (bus.sample_valid) begin
                    sample_r <= bus.sample_in;
                    filt_r   <= bus.filt;
                    mode_r   <= bus.mode;
                    fc_r     <= bus.fc;
                    res_r    <= bus.res;
                    vol_r    <= bus.vol;
                    ch_idx   <= '0;
                    xf       <= '0;
                    xb       <= '0;
                end
                S_MIX: begin
                    if (filt_r[ch_idx]) xf <= add_res;
                    else                xb <= add_res;
                    ch_idx <= ch_idx + CW'(1);
                end
                S_HP:  hp <= add_res;
                S_BP:  bp <= add_res;
                S_LP:  lp <= add_res;
                S_OUT: sample_out_r <= {~o_val[DW-1], o_val[DW-2:0]};
                default: ;
            endcase
        end
    end

    assign bus.ready      = ready;
    assign bus.sample_out = sample_out_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_filter_mc.sv
// Directed bench for filter_mc: a frame-level reference model feeds a scoreboard
// queue that the out_valid monitor drains and compares.
module tb_filter_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    filter_mc_if #(.DW(8), .NCH(3), .FW(4)) bus ();

    filter_mc #(.DW(8), .NCH(3), .FW(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] exp;
        int         acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int ov_cnt = 0;
    int ovr_cnt = 0;
    int m_bp = 0;
    int m_lp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int sat12(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic logic [7:0] model(input logic [23:0] smp, input logic [2:0] f,
                                         input logic [2:0] m, input logic [3:0] fcv,
                                         input logic [3:0] rv, input logic [3:0] vv);
        int xf, xb, hp, s, sel, t, o, fci, ri, vi;
        xf = 0; xb = 0;
        fci = int'(fcv); ri = int'(rv); vi = int'(vv);
        for (int i = 0; i < 3; i++) begin
            s = int'(smp[i*8 +: 8]) - 128;
            if (f[i]) xf = sat12(xf + s);
            else      xb = sat12(xb + s);
        end
        hp   = sat12(sat12(xf - m_lp) - ((m_bp * (16 - ri)) >>> 3));
        m_bp = sat12(m_bp + ((hp * fci) >>> 4));
        m_lp = sat12(m_lp + ((m_bp * fci) >>> 4));
        sel  = sat12(sat12((m[0] ? m_lp : 0) + (m[1] ? m_bp : 0)) + (m[2] ? hp : 0));
        t    = sat12(sel + xb);
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        o = (t * vi) >>> 4;
        return 8'(o + 128);
    endfunction

    always @(negedge clk) begin
        if (bus.overrun) ovr_cnt++;
        if (rst_n && bus.out_valid) begin
            exp_t e;
            ov_cnt++;
            if (q.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sample_out", 32'(bus.sample_out), 32'(e.exp));
                chk("latency", 32'(cyc - e.acc), 32'd7);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.sample_in = 24'($urandom);
        bus.filt      = 3'($urandom);
        bus.mode      = 3'($urandom);
        bus.fc        = 4'($urandom);
        bus.res       = 4'($urandom);
        bus.vol       = 4'($urandom);
    endtask

    task automatic send(input logic [23:0] smp, input logic [2:0] f, input logic [2:0] m,
                        input logic [3:0] fcv, input logic [3:0] rv, input logic [3:0] vv,
                        input bit b2b);
        logic [7:0] e;
        for (int i = 0; i < 40 && !bus.ready; i++) step();
        chk("ready_wait", 32'(bus.ready), 32'd1);
        if (b2b) chk("b2b_in_out_valid_cycle", 32'(bus.out_valid), 32'd1);
        bus.sample_in    = smp;
        bus.filt         = f;
        bus.mode         = m;
        bus.fc           = fcv;
        bus.res          = rv;
        bus.vol          = vv;
        bus.sample_valid = 1'b1;
        e = model(smp, f, m, fcv, rv, vv);
        step();
        q.push_back('{e, cyc});
        bus.sample_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && q.size() != 0; i++) step();
        chk("drain", 32'(q.size()), 32'd0);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int ov_snap;
        bus.sample_valid = 1'b0;
        scramble();

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            bus.sample_valid = 1'($urandom);
            scramble();
            step();
            chk("rst_overrun", 32'(bus.overrun), 32'd0);
        end
        chk("rst_sample_out", 32'(bus.sample_out), 32'h80);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        bus.sample_valid = 1'b0;
        rst_n = 1'b1;

        // Full bypass, saturating sum
        send(24'hC0C0C0, 3'b000, 3'b000, 4'd0, 4'd0, 4'd15, 1'b0);
        wait_idle();
        chk("bypass_sat_value", 32'(bus.sample_out), 32'hF7);

        // Single bypass voice at half volume
        send(24'h808090, 3'b000, 3'b000, 4'd0, 4'd0, 4'd8, 1'b0);
        wait_idle();
        chk("single_voice_value", 32'(bus.sample_out), 32'h88);

        // LP settling; floor shifts leave lp a few LSBs short of the input
        for (int i = 0; i < 100; i++)
            send(24'h8080A0, 3'b001, 3'b001, 4'd8, 4'd0, 4'd15, 1'b0);
        wait_idle();

        // Abort a frame in MIX_1
        send(24'h8080A0, 3'b001, 3'b001, 4'd8, 4'd0, 4'd15, 1'b0);
        step();
        rst_n = 1'b0;
        q.delete();
        m_bp = 0;
        m_lp = 0;
        ov_snap = ov_cnt;
        #1;
        chk("abort_sample_out", 32'(bus.sample_out), 32'h80);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("abort_no_out_valid", 32'(ov_cnt), 32'(ov_snap));
        chk("abort_hold_sample_out", 32'(bus.sample_out), 32'h80);

        // fc = 0 freezes the filter at its cleared state
        for (int i = 0; i < 3; i++) begin
            send(24'h8080FF, 3'b001, 3'b001, 4'd0, 4'd0, 4'd15, 1'b0);
            wait_idle();
            chk("fc0_value", 32'(bus.sample_out), 32'h80);
        end

        // LP settling with HP output selected
        for (int i = 0; i < 100; i++)
            send(24'h8080A0, 3'b001, 3'b100, 4'd8, 4'd0, 4'd15, 1'b0);
        wait_idle();

        // Overrun during a frame, then back-to-back accept
        ov_snap = ov_cnt;
        ovr_cnt = 0;
        send(24'h80A080, 3'b000, 3'b000, 4'd3, 4'd5, 4'd15, 1'b0);
        step();
        bus.sample_valid = 1'b1;
        bus.sample_in    = 24'hFFFFFF;
        step();
        bus.sample_valid = 1'b0;
        chk("overrun_pulse", 32'(bus.overrun), 32'd1);
        step();
        chk("overrun_one_cycle", 32'(bus.overrun), 32'd0);
        send(24'h707080, 3'b100, 3'b010, 4'd6, 4'd9, 4'd12, 1'b1);
        wait_idle();
        chk("overrun_count", 32'(ovr_cnt), 32'd1);
        chk("out_valid_count", 32'(ov_cnt - ov_snap), 32'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
